scan_sel_seq: RTL

Sequencer that produces the 3-bit channel index feeding the 3-to-8 decoder. On a start request it walks the enabled channels of an 8-bit mask in ascending order, holding each index for a programmable dwell time. It signals completion with a one-cycle done pulse. It sits directly upstream of the decoder: `sel` drives the decoder's 3-bit input, and `sel_valid` qualifies the decoder's one-hot output.

---
 rtl/scan_sel_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/scan_sel_seq.sv
// Purpose : walks the enabled channels of an 8-bit mask in ascending order and
//           presents each index on sel_o for DWELL cycles ahead of a 3-to-8 decoder.
// Latency : start accepted at edge k -> first channel valid from cycle k+1;
//           done_o in cycle k+1+N*DWELL. Nothing applies backpressure; start is
//           honoured only in IDLE and is never queued.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      scan request, sampled only in IDLE
//   abort_i      abandon the current scan (no done pulse)
//   mask_i[7:0]  channel enables, latched when start is accepted
//   sel_o[2:0]   channel index to the decoder (held in IDLE/DONE)
//   sel_valid_o  sel_o is a live, enabled channel
//   busy_o       scan in progress, including the DONE cycle
//   done_o       one-cycle completion pulse
//
// Optional feature: define SCAN_SEL_SEQ_LOOP_EN for continuous scanning. After
// the highest enabled channel the mask is re-sampled live and the scan wraps to
// its lowest set bit without a gap; an empty re-sample returns to IDLE silently.

module scan_sel_seq #(
    parameter int unsigned DWELL = 4    // cycles per channel, 1..16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] mask_i,
    output logic [2:0] sel_o,
    output logic       sel_valid_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Terminal count; a 4-bit counter covers DWELL=16 as 0..15 without wrapping.
    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] mask_q,  mask_d;
    logic [2:0] sel_q,   sel_d;
    logic [3:0] cnt_q,   cnt_d;

    // Index of the lowest set bit; 0 when the mask is empty (callers guard).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next-higher set bit strictly above the current channel.
    logic [2:0] nxt_sel;
    logic       nxt_found;

    always_comb begin
        nxt_sel   = 3'd0;
        nxt_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(sel_q))) begin
                nxt_sel   = 3'(i);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start; the start is dropped.
                if (start_i && !abort_i) begin
                    if (mask_i != 8'd0) begin
                        mask_d  = mask_i;
                        sel_d   = lowest_set(mask_i);
                        cnt_d   = 4'd0;
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DWELL: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = 4'd0;
                    if (nxt_found) begin
                        sel_d = nxt_sel;
                    end else begin
`ifdef SCAN_SEL_SEQ_LOOP_EN
                        // Wrap using the live mask so software can retarget
                        // a running scan at pass boundaries.
                        if (mask_i != 8'd0) begin
                            mask_d = mask_i;
                            sel_d  = lowest_set(mask_i);
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mask_q  <= 8'd0;
            sel_q   <= 3'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only: no input-to-output paths.
    assign sel_o       = sel_q;
    assign sel_valid_o = (state_q == S_DWELL);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule
